// File: rtl/matmul_pkg.sv
// Shared types and sizing for the 2x2 matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StMac,
        StOut
    } state_e;

    localparam int unsigned DefaultW = 4;
    localparam int unsigned BeatW    = 2;
    localparam int unsigned StepW    = 3;

    // Result width: a 2W-bit product plus one bit of carry for the two-term sum.
    function automatic int unsigned cw_of(int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate: sum = a*b + (clear ? 0 : acc).
// Define MATMUL_SIGNED_EN for two's-complement operands; default build is unsigned.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2*W:0] acc,
    input  logic         clear,
    output logic [2*W:0] sum
);

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod;
    logic [2*W:0]   prod_ext;

`ifdef MATMUL_SIGNED_EN
    assign a_ext    = {{W{a[W-1]}}, a};
    assign b_ext    = {{W{b[W-1]}}, b};
    // Low 2W bits of the sign-extended product are the exact signed product.
    assign prod     = a_ext * b_ext;
    assign prod_ext = {prod[2*W-1], prod};
`else
    assign a_ext    = {{W{1'b0}}, a};
    assign b_ext    = {{W{1'b0}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {1'b0, prod};
`endif

    assign sum = prod_ext + (clear ? '0 : acc);

endmodule

// File: rtl/matmul_2x2_sequencer.sv
// Loads 2x2 operands A and B from a beat stream, runs the eight products through one
// shared MAC, then streams out C = A*B. Signedness follows MATMUL_SIGNED_EN.
module matmul_2x2_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W:0]   out_data,
    output logic [1:0]     out_idx,
    output logic           busy
);

    localparam int unsigned CW = cw_of(W);

    state_e             state_q, state_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [CW-1:0]      acc_q, acc_d;
    logic [W-1:0]       a_q [4];
    logic [W-1:0]       b_q [4];
    logic [CW-1:0]      c_q [4];

    logic               load_en;
    logic               c_we;
    logic               i_sel, j_sel, p_sel;
    logic [W-1:0]       mac_a, mac_b;
    logic [CW-1:0]      mac_sum;

    // Step bits decode straight into the (i, j, p) of a_ip * b_pj.
    assign {i_sel, j_sel, p_sel} = step_q;
    assign mac_a = a_q[{i_sel, p_sel}];
    assign mac_b = b_q[{p_sel, j_sel}];

    matmul_mac #(
        .W (W)
    ) u_mac (
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc_q),
        .clear (~p_sel),
        .sum   (mac_sum)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        step_d    = step_q;
        acc_d     = acc_q;
        load_en   = 1'b0;
        c_we      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    beat_d  = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StMac;
                        step_d  = '0;
                    end
                end
            end
            StMac: begin
                busy   = 1'b1;
                acc_d  = mac_sum;
                c_we   = p_sel;
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = StOut;
                    beat_d  = '0;
                end
            end
            StOut: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            beat_q  <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            // Beat bit 1 selects A or B, bit 0 selects the row; each beat carries one row.
            if (load_en) begin
                if (!beat_q[1]) begin
                    a_q[{beat_q[0], 1'b0}] <= in_data[W-1:0];
                    a_q[{beat_q[0], 1'b1}] <= in_data[2*W-1:W];
                end else begin
                    b_q[{beat_q[0], 1'b0}] <= in_data[W-1:0];
                    b_q[{beat_q[0], 1'b1}] <= in_data[2*W-1:W];
                end
            end
            if (c_we) begin
                c_q[{i_sel, j_sel}] <= mac_sum;
            end
        end
    end

    assign out_data = (state_q == StOut) ? c_q[beat_q] : '0;
    assign out_idx  = (state_q == StOut) ? beat_q : 2'd0;

endmodule

// File: tb/tb_matmul_2x2_sequencer.sv
// Self-checking bench for matmul_2x2_sequencer: vector table plus reset/junk sequences.
module tb_matmul_2x2_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2 * W + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  out_data;
    logic [1:0]     out_idx;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_2x2_sequencer #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    // Matrices packed row-major: element (r,c) at bits [(2r+c)*W +: W].
    typedef struct {
        logic [4*W-1:0]  a;
        logic [4*W-1:0]  b;
        logic [4*CW-1:0] exp;
        int              gap_max;
        int              stall_idx;
        int              stall_len;
        bit              junk;
    } vec_t;

    vec_t vecs[12];

    function automatic int elem(input logic [4*W-1:0] m, input int k);
        logic [W-1:0] e;
        e = m[k*W +: W];
`ifdef MATMUL_SIGNED_EN
        return int'($signed(e));
`else
        return int'(e);
`endif
    endfunction

    // Reference: plain matrix product.
    function automatic logic [4*CW-1:0] ref_mul(input logic [4*W-1:0] a,
                                                input logic [4*W-1:0] b);
        logic [4*CW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int p = 0; p < 2; p++) s += elem(a, i*2+p) * elem(b, p*2+j);
                r[(i*2+j)*CW +: CW] = s[CW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [4*CW-1:0] pack_c(input int c0, input int c1,
                                               input int c2, input int c3);
        logic [31:0] t0, t1, t2, t3;
        t0 = c0; t1 = c1; t2 = c2; t3 = c3;
        return {t3[CW-1:0], t2[CW-1:0], t1[CW-1:0], t0[CW-1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4*W-1:0] a, input logic [4*W-1:0] b, input int gap_max,
                        input bit junk, output int accept_cyc);
        logic [2*W-1:0] d;
        int gaps, guard;
        accept_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            d = (k < 2) ? a[k*2*W +: 2*W] : b[(k-2)*2*W +: 2*W];
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat (gaps) tick();
            in_valid = 1'b1;
            in_data  = d;
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            check("in_ready before beat", 32'(in_ready), 32'd1);
            accept_cyc = cyc;
            tick();
        end
        in_valid = junk;
        in_data  = 8'($urandom);
        check("in_ready low in MAC", 32'(in_ready), 32'd0);
        check("busy in MAC", 32'(busy), 32'd1);
    endtask

    task automatic recv(input logic [4*CW-1:0] exp, input int stall_idx, input int stall_len,
                        input bit junk, input int accept_cyc);
        int guard;
        logic [CW-1:0] e;
        for (int k = 0; k < 4; k++) begin
            e = exp[k*CW +: CW];
            guard = 0;
            while (!out_valid && guard < 40) begin
                if (junk) in_data = 8'($urandom);
                tick();
                guard++;
            end
            check("out_valid arrives", 32'(out_valid), 32'd1);
            if (k == 0) check("first out latency", 32'(cyc - accept_cyc), 32'd9);
            if (k == stall_idx) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    tick();
                    check("held out_data", 32'(out_data), 32'(e));
                    check("held out_idx", 32'(out_idx), 32'(k));
                end
            end
            check("out_data", 32'(out_data), 32'(e));
            check("out_idx", 32'(out_idx), 32'(k));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        check("in_ready after c11", 32'(in_ready), 32'd1);
        check("out_valid after c11", 32'(out_valid), 32'd0);
        check("busy after c11", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int acc_cyc;
        send(v.a, v.b, v.gap_max, v.junk, acc_cyc);
        recv(v.exp, v.stall_idx, v.stall_len, v.junk, acc_cyc);
    endtask

    initial begin
        logic [4*CW-1:0] exp1;
        vec_t hv;
        int acc_cyc;

`ifdef MATMUL_SIGNED_EN
        exp1 = ref_mul(16'h4321, 16'h8765);
        vecs[1] = '{a: 16'h8888, b: 16'h8888, exp: pack_c(128, 128, 128, 128),
                    gap_max: 0, stall_idx: 4, stall_len: 0, junk: 0};
`else
        exp1 = pack_c(19, 22, 43, 50);
        vecs[1] = '{a: 16'hffff, b: 16'hffff, exp: pack_c(450, 450, 450, 450),
                    gap_max: 0, stall_idx: 4, stall_len: 0, junk: 0};
`endif
        vecs[0] = '{a: 16'h4321, b: 16'h8765, exp: exp1,
                    gap_max: 0, stall_idx: 4, stall_len: 0, junk: 0};
        vecs[2] = '{a: 16'h4321, b: 16'h8765, exp: exp1,
                    gap_max: 0, stall_idx: 1, stall_len: 3, junk: 0};
        vecs[3] = '{a: 16'h4321, b: 16'h8765, exp: exp1,
                    gap_max: 3, stall_idx: 4, stall_len: 0, junk: 0};
        vecs[4] = '{a: 16'h4321, b: 16'h8765, exp: exp1,
                    gap_max: 0, stall_idx: 4, stall_len: 0, junk: 1};
        for (int n = 5; n < 12; n++) begin
            vecs[n].a         = 16'($urandom);
            vecs[n].b         = 16'($urandom);
            vecs[n].exp       = ref_mul(vecs[n].a, vecs[n].b);
            vecs[n].gap_max   = int'($urandom_range(3, 0));
            vecs[n].stall_idx = int'($urandom_range(4, 0));
            vecs[n].stall_len = int'($urandom_range(3, 1));
            vecs[n].junk      = 1'($urandom_range(1, 0));
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_idx", 32'(out_idx), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        for (int n = 0; n < 12; n++) run_vec(vecs[n]);

        // Reset during MAC step 4, then a fresh load must start at beat 0.
        send(16'h4321, 16'h8765, 0, 0, acc_cyc);
        repeat (3) tick();
        check("busy mid MAC", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-MAC reset in_ready", 32'(in_ready), 32'd1);
        check("mid-MAC reset out_valid", 32'(out_valid), 32'd0);
        check("mid-MAC reset busy", 32'(busy), 32'd0);
        hv.a = 16'h1001;
        hv.b = 16'h6789;
`ifdef MATMUL_SIGNED_EN
        hv.exp = ref_mul(hv.a, hv.b);
`else
        hv.exp = pack_c(9, 8, 7, 6);
`endif
        hv.gap_max   = 1;
        hv.stall_idx = 2;
        hv.stall_len = 2;
        hv.junk      = 1'b0;
        run_vec(hv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
